ysyx_22040210_trap_ctrl: RTL and testbench
==========================================

Name: ysyx_22040210_trap_ctrl

Overview:
Trap sequencer that drives the machine-mode CSR register file through its write port and one read port. It accepts ECALL and MRET requests from the commit stage and performs the CSR update sequence over several cycles. When the sequence ends it issues a one-cycle PC redirect to the fetch stage. It stalls the pipeline while a sequence is in flight.

Parameters:
XLEN, 64, data width of CSR values and PCs
CSR_AW, 12, CSR address width
ECALL_CAUSE, 11, mcause value written on ECALL (environment call from M-mode)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-low
req_valid_i  input  1  commit stage presents a trap request
req_ecall_i  input  1  request is ECALL (qualified by req_valid_i)
req_mret_i  input  1  request is MRET (qualified by req_valid_i)
req_pc_i  input  XLEN  PC of the ECALL/MRET instruction
req_ready_o  output  1  controller idle; request accepted when req_valid_i & req_ready_o
busy_o  output  1  sequence in flight; pipeline must hold
csr_we_o  output  1  CSR write enable
csr_waddr_o  output  CSR_AW  CSR write address
csr_wdata_o  output  XLEN  CSR write data
csr_re_o  output  1  CSR read enable
csr_raddr_o  output  CSR_AW  CSR read address
csr_rdata_i  input  XLEN  CSR read data, combinational, same cycle as csr_re_o
redirect_o  output  1  one-cycle PC redirect pulse
redirect_pc_o  output  XLEN  redirect target, valid while redirect_o=1

Behaviour:
- CSR addresses: MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342.
- States: IDLE, E_EPC, E_CAUSE, E_SRD, E_SWR, E_VEC, M_SRD, M_SWR, M_EPC.
- Outputs are decoded from the state register and internal latches. Reset (rst=0, asynchronous) forces IDLE, all outputs 0 except req_ready_o=1, and clears the latched PC and mstatus.
- req_ready_o = (state==IDLE). busy_o = !req_ready_o.
- Accepting a request in IDLE latches req_pc_i.
  - ECALL goes to E_EPC.
  - MRET goes to M_SRD.
  - If both ECALL and MRET are set, ECALL wins.
  - req_valid_i with neither bit set is ignored.
- E_EPC: we=1, waddr=MEPC, wdata=latched PC.
- E_CAUSE: we=1, waddr=MCAUSE, wdata=ECALL_CAUSE.
- E_SRD: re=1, raddr=MSTATUS; csr_rdata_i is latched. we=0 here so the CSR file's write-to-read bypass cannot form a loop.
- E_SWR: we=1, waddr=MSTATUS. wdata = latched value with:
  - MPIE[7] <= MIE[3]
  - MIE[3] <= 0
  - MPP[12:11] <= 2'b11
  - all other bits unchanged
- E_VEC: re=1, raddr=MTVEC, redirect_o=1, redirect_pc_o={csr_rdata_i[XLEN-1:2],2'b00} (direct mode only; mode bits ignored). Next state IDLE.
- M_SRD: read MSTATUS and latch it.
- M_SWR: write MSTATUS with:
  - MIE[3] <= MPIE[7]
  - MPIE[7] <= 1
  - MPP[12:11] <= 2'b11 (M-only hart)
- M_EPC: re=1, raddr=MEPC, redirect_o=1, redirect_pc_o={csr_rdata_i[XLEN-1:2],2'b00}. Next state IDLE.
- Latency, with the accept cycle as cycle 0:
  - ECALL: redirect in cycle 5, req_ready_o back in cycle 6.
  - MRET: redirect in cycle 3, ready in cycle 4.
- Exactly one of csr_we_o / csr_re_o is active in non-IDLE states, except E_VEC and M_EPC, which only read. Both are 0 in IDLE.
- Unused output fields (addr/data when the matching enable is 0) are driven 0.
- Requests arriving while busy are not accepted. The upstream stage holds req_valid_i until ready.
- Reset mid-sequence aborts immediately with no redirect. CSR writes already issued remain in the CSR file.
- Illegal or unreachable state goes to IDLE.

Test Plan:
- Reset: hold rst=0 with req_valid_i=1 -> all outputs 0, req_ready_o=1; release -> IDLE, no CSR traffic.
- ECALL: mstatus=0xa00001808, mtvec=0x80000501, req_pc_i=0x80000100 -> cycle 1 writes MEPC=0x80000100; cycle 2 writes MCAUSE=11; cycle 4 writes MSTATUS=0xa00001880; cycle 5 redirect_o=1 with pc 0x80000500; busy_o=1 for cycles 1-5.
- MRET: mstatus=0xa00001880, mepc=0x80000104 -> cycle 2 writes MSTATUS=0xa00001888; cycle 3 redirect to 0x80000104; ready in cycle 4.
- Back-to-back: ECALL then MRET held valid during busy -> MRET accepted only in cycle 6; its redirect appears in cycle 9; no request lost or duplicated.
- Priority and idle: req_ecall_i=req_mret_i=1 -> ECALL sequence only; req_valid_i=1 with both bits 0 -> no state change.
- Mid-sequence reset: assert rst=0 in E_SRD -> next edge IDLE, redirect_o never asserted, CSR file keeps mepc/mcause already written.

Source files
------------

// File: rtl/ysyx_22040210_trap_ctrl.sv
// Trap sequencer: walks the M-mode CSR update for ECALL/MRET over several cycles,
// then issues a one-cycle fetch redirect. Holds the pipeline while busy.
module ysyx_22040210_trap_ctrl #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned CSR_AW      = 12,
    parameter int unsigned ECALL_CAUSE = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              req_ecall_i,
    input  logic              req_mret_i,
    input  logic [XLEN-1:0]   req_pc_i,
    output logic              req_ready_o,
    output logic              busy_o,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              csr_re_o,
    output logic [CSR_AW-1:0] csr_raddr_o,
    input  logic [XLEN-1:0]   csr_rdata_i,
    output logic              redirect_o,
    output logic [XLEN-1:0]   redirect_pc_o
);

    localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] ADDR_MTVEC   = CSR_AW'(12'h305);
    localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_E_EPC   = 4'd1,
        S_E_CAUSE = 4'd2,
        S_E_SRD   = 4'd3,
        S_E_SWR   = 4'd4,
        S_E_VEC   = 4'd5,
        S_M_SRD   = 4'd6,
        S_M_SWR   = 4'd7,
        S_M_EPC   = 4'd8
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] ecall_mstatus, mret_mstatus;
    logic            accept;

    assign accept = (state_q == S_IDLE) && req_valid_i;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ECALL has priority over MRET
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
                if (accept && req_ecall_i) begin
                    state_d = S_E_EPC;
                end else if (accept && req_mret_i) begin
                    state_d = S_M_SRD;
                end
            end
            S_E_EPC:   state_d = S_E_CAUSE;
            S_E_CAUSE: state_d = S_E_SRD;
            S_E_SRD:   state_d = S_E_SWR;
            S_E_SWR:   state_d = S_E_VEC;
            S_E_VEC:   state_d = S_IDLE;
            S_M_SRD:   state_d = S_M_SWR;
            S_M_SWR:   state_d = S_M_EPC;
            S_M_EPC:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Latched PC and mstatus snapshot
    always_comb begin
        pc_d      = pc_q;
        mstatus_d = mstatus_q;
        if (accept && (req_ecall_i || req_mret_i)) begin
            pc_d = req_pc_i;
        end
        if ((state_q == S_E_SRD) || (state_q == S_M_SRD)) begin
            mstatus_d = csr_rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= '0;
            mstatus_q <= '0;
        end else begin
            pc_q      <= pc_d;
            mstatus_q <= mstatus_d;
        end
    end

    // mstatus rewrite for trap entry and return (M-only hart, MPP stays 11)
    always_comb begin
        ecall_mstatus        = mstatus_q;
        ecall_mstatus[7]     = mstatus_q[3];
        ecall_mstatus[3]     = 1'b0;
        ecall_mstatus[12:11] = 2'b11;
        mret_mstatus         = mstatus_q;
        mret_mstatus[3]      = mstatus_q[7];
        mret_mstatus[7]      = 1'b1;
        mret_mstatus[12:11]  = 2'b11;
    end

    // Output decode; unused fields held at zero
    always_comb begin
        req_ready_o   = 1'b0;
        csr_we_o      = 1'b0;
        csr_waddr_o   = '0;
        csr_wdata_o   = '0;
        csr_re_o      = 1'b0;
        csr_raddr_o   = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        case (state_q)
            S_IDLE: req_ready_o = 1'b1;
            S_E_EPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = pc_q;
            end
            S_E_CAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = XLEN'(ECALL_CAUSE);
            end
            S_E_SRD, S_M_SRD: begin
                csr_re_o    = 1'b1;
                csr_raddr_o = ADDR_MSTATUS;
            end
            S_E_SWR: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = ecall_mstatus;
            end
            S_M_SWR: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = mret_mstatus;
            end
            S_E_VEC: begin
                csr_re_o      = 1'b1;
                csr_raddr_o   = ADDR_MTVEC;
                redirect_o    = 1'b1;
                redirect_pc_o = {csr_rdata_i[XLEN-1:2], 2'b00};
            end
            S_M_EPC: begin
                csr_re_o      = 1'b1;
                csr_raddr_o   = ADDR_MEPC;
                redirect_o    = 1'b1;
                redirect_pc_o = {csr_rdata_i[XLEN-1:2], 2'b00};
            end
            default: req_ready_o = 1'b0;
        endcase
    end

    assign busy_o = !req_ready_o;

endmodule

// File: tb/tb_ysyx_22040210_trap_ctrl.sv
// Scoreboard bench for the trap sequencer with a small behavioural CSR file.
module tb_ysyx_22040210_trap_ctrl;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ecall, req_mret;
    logic [63:0] req_pc;
    logic        req_ready, busy;
    logic        csr_we, csr_re;
    logic [11:0] csr_waddr, csr_raddr;
    logic [63:0] csr_wdata, csr_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;

    ysyx_22040210_trap_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ecall_i  (req_ecall),
        .req_mret_i   (req_mret),
        .req_pc_i     (req_pc),
        .req_ready_o  (req_ready),
        .busy_o       (busy),
        .csr_we_o     (csr_we),
        .csr_waddr_o  (csr_waddr),
        .csr_wdata_o  (csr_wdata),
        .csr_re_o     (csr_re),
        .csr_raddr_o  (csr_raddr),
        .csr_rdata_i  (csr_rdata),
        .redirect_o   (redirect),
        .redirect_pc_o(redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural CSR file: combinational read, write on rising edge, bench preload port
    logic [63:0] r_mstatus = 64'h0, r_mtvec = 64'h0, r_mepc = 64'h0, r_mcause = 64'h0;
    logic        pl_we = 1'b0;
    logic [11:0] pl_addr = 12'h0;
    logic [63:0] pl_data = 64'h0;

    always @(posedge clk) begin
        if (csr_we || pl_we) begin
            case (csr_we ? csr_waddr : pl_addr)
                A_MSTATUS: r_mstatus <= csr_we ? csr_wdata : pl_data;
                A_MTVEC:   r_mtvec   <= csr_we ? csr_wdata : pl_data;
                A_MEPC:    r_mepc    <= csr_we ? csr_wdata : pl_data;
                A_MCAUSE:  r_mcause  <= csr_we ? csr_wdata : pl_data;
                default:   ;
            endcase
        end
    end

    always_comb begin
        csr_rdata = 64'h0;
        if (csr_re) begin
            case (csr_raddr)
                A_MSTATUS: csr_rdata = r_mstatus;
                A_MTVEC:   csr_rdata = r_mtvec;
                A_MEPC:    csr_rdata = r_mepc;
                A_MCAUSE:  csr_rdata = r_mcause;
                default:   csr_rdata = 64'h0;
            endcase
        end
    end

    typedef struct {
        int          cyc;
        bit          redir;
        logic [11:0] addr;
        logic [63:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input bit r, input logic [11:0] a, input logic [63:0] d);
        ev_t e;
        e.cyc = c; e.redir = r; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Observes every CSR write and redirect, checks against the expected queue
    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (csr_we || redirect) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {63'h0, redirect}, 64'hffff_ffff_ffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_cycle", 64'(cyc), 64'(e.cyc));
                    chk("ev_kind", {63'h0, redirect}, {63'h0, e.redir});
                    if (e.redir) chk("redirect_pc", redirect_pc, e.data);
                    else begin
                        chk("waddr", {52'h0, csr_waddr}, {52'h0, e.addr});
                        chk("wdata", csr_wdata, e.data);
                    end
                end
            end
            if (csr_we && csr_re) chk("we_re_exclusive", 64'h1, 64'h0);
            if (!csr_we && (csr_waddr != 12'h0 || csr_wdata != 64'h0))
                chk("idle_wfields", {52'h0, csr_waddr} | csr_wdata, 64'h0);
            if (!csr_re && csr_raddr != 12'h0) chk("idle_raddr", {52'h0, csr_raddr}, 64'h0);
            if (!redirect && redirect_pc != 64'h0) chk("idle_rpc", redirect_pc, 64'h0);
            if (busy == req_ready) chk("busy_vs_ready", {63'h0, busy}, {63'h0, ~req_ready});
        end
    endtask

    // Called at a negedge; drives a request until accepted and queues its expected events
    task automatic do_req(input bit e, input bit m, input logic [63:0] pc,
                          input logic [63:0] exp_ms, input logic [63:0] exp_pc,
                          input bit full, output int acc);
        int k;
        req_valid = 1'b1; req_ecall = e; req_mret = m; req_pc = pc;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk("accept_timeout", 64'h0, 64'h1);
        acc = cyc;
        if (e) begin
            push_ev(acc + 1, 1'b0, A_MEPC, pc);
            push_ev(acc + 2, 1'b0, A_MCAUSE, 64'd11);
            if (full) begin
                push_ev(acc + 4, 1'b0, A_MSTATUS, exp_ms);
                push_ev(acc + 5, 1'b1, 12'h0, exp_pc);
            end
        end else begin
            push_ev(acc + 2, 1'b0, A_MSTATUS, exp_ms);
            push_ev(acc + 3, 1'b1, 12'h0, exp_pc);
        end
        @(negedge clk);
        req_valid = 1'b0; req_ecall = 1'b0; req_mret = 1'b0; req_pc = 64'h0;
    endtask

    task automatic preload(input logic [11:0] a, input logic [63:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // From negedge acc+1: busy for cycles 1..last, ready at last+1
    task automatic chk_busy(input int acc, input int last);
        while (cyc <= acc + last + 1) begin
            chk("busy_window", {63'h0, busy}, {63'h0, cyc <= acc + last});
            @(negedge clk);
        end
    endtask

    int a1, a2;

    initial begin
        rst = 1'b0; req_valid = 1'b1; req_ecall = 1'b1; req_mret = 1'b0; req_pc = 64'h8000_0000;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1);
            end
        join_none

        // Reset held with a request pending
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_we", {63'h0, csr_we}, 64'h0);
        chk("rst_re", {63'h0, csr_re}, 64'h0);
        chk("rst_redirect", {63'h0, redirect}, 64'h0);
        req_valid = 1'b0; req_ecall = 1'b0; req_pc = 64'h0;
        rst = 1'b1;
        preload(A_MSTATUS, 64'ha_0000_1808);
        preload(A_MTVEC, 64'h8000_0501);
        repeat (2) @(negedge clk);
        chk("post_rst_ready", {63'h0, req_ready}, 64'h1);

        // ECALL with MIE=1
        do_req(1'b1, 1'b0, 64'h8000_0100, 64'ha_0000_1880, 64'h8000_0500, 1'b1, a1);
        chk_busy(a1, 5);

        // MRET
        preload(A_MEPC, 64'h8000_0104);
        do_req(1'b0, 1'b1, 64'h8000_0500, 64'ha_0000_1888, 64'h8000_0104, 1'b1, a1);
        chk_busy(a1, 3);

        // Back-to-back ECALL then MRET held while busy
        do_req(1'b1, 1'b0, 64'h8000_0200, 64'ha_0000_1880, 64'h8000_0500, 1'b1, a1);
        do_req(1'b0, 1'b1, 64'h8000_0500, 64'ha_0000_1888, 64'h8000_0200, 1'b1, a2);
        chk("b2b_accept_cycle", 64'(a2), 64'(a1 + 6));
        repeat (6) @(negedge clk);

        // Both bits set: ECALL wins
        do_req(1'b1, 1'b1, 64'h8000_0300, 64'ha_0000_1880, 64'h8000_0500, 1'b1, a1);
        chk_busy(a1, 5);

        // Valid with neither bit: ignored
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("null_req_ready", {63'h0, req_ready}, 64'h1);
        end
        req_valid = 1'b0;

        // ECALL with MIE=0, MPIE=1
        preload(A_MSTATUS, 64'h80);
        do_req(1'b1, 1'b0, 64'h8000_0700, 64'h1800, 64'h8000_0500, 1'b1, a1);
        chk_busy(a1, 5);

        // MRET with MPIE=0 and unaligned mepc
        preload(A_MSTATUS, 64'h0);
        preload(A_MEPC, 64'h8000_0403);
        do_req(1'b0, 1'b1, 64'h0, 64'h1880, 64'h8000_0400, 1'b1, a1);
        chk_busy(a1, 3);

        // Reset in E_SRD aborts without redirect
        preload(A_MSTATUS, 64'ha_0000_1808);
        do_req(1'b1, 1'b0, 64'h8000_0600, 64'h0, 64'h0, 1'b0, a1);
        while (cyc < a1 + 3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ready", {63'h0, req_ready}, 64'h1);
        chk("midrst_redirect", {63'h0, redirect}, 64'h0);
        chk("midrst_re", {63'h0, csr_re}, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_mepc_kept", r_mepc, 64'h8000_0600);
        chk("midrst_mcause_kept", r_mcause, 64'd11);
        chk("midrst_mstatus_untouched", r_mstatus, 64'ha_0000_1808);

        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
